// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the Keccak-f[1600] core: one-hot round index, round enable, held done flag.
// Optional build macro ROUND_IDX_BIN_EN adds a registered binary round index output (round_idx_o).
module keccak_round_ctrl #(
    parameter int ROUNDS = 24
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              out_ack_i,
    output logic              in_ready_o,
    output logic [ROUNDS-1:0] round_onehot_o,
    output logic              round_en_o,
    output logic              first_round_o,
    output logic              last_round_o,
    output logic              busy_o,
`ifdef ROUND_IDX_BIN_EN
    output logic [4:0]        round_idx_o,
`endif
    output logic              out_valid_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ROUNDS-1:0] onehot_q, onehot_d;
`ifdef ROUND_IDX_BIN_EN
    logic [4:0]        idx_q, idx_d;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            onehot_q <= '0;
`ifdef ROUND_IDX_BIN_EN
            idx_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
`ifdef ROUND_IDX_BIN_EN
            idx_q    <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
`ifdef ROUND_IDX_BIN_EN
        idx_d    = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    onehot_d = ROUNDS'(1);
`ifdef ROUND_IDX_BIN_EN
                    idx_d    = '0;
`endif
                end
            end
            // Inputs are deliberately ignored here; a run always completes all rounds.
            RUN: begin
                if (onehot_q[ROUNDS-1]) begin
                    state_d  = DONE;
                    onehot_d = '0;
`ifdef ROUND_IDX_BIN_EN
                    idx_d    = '0;
`endif
                end else begin
                    onehot_d = onehot_q << 1;
`ifdef ROUND_IDX_BIN_EN
                    idx_d    = idx_q + 5'd1;
`endif
                end
            end
            // start coinciding with out_ack only returns to IDLE; no back-to-back launch.
            DONE: begin
                if (out_ack_i) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
`ifdef ROUND_IDX_BIN_EN
                idx_d    = '0;
`endif
            end
        endcase
    end

    assign in_ready_o     = (state_q == IDLE);
    assign busy_o         = (state_q == RUN);
    assign round_en_o     = (state_q == RUN);
    assign out_valid_o    = (state_q == DONE);
    assign round_onehot_o = onehot_q;
    assign first_round_o  = round_en_o & onehot_q[0];
    assign last_round_o   = round_en_o & onehot_q[ROUNDS-1];
`ifdef ROUND_IDX_BIN_EN
    assign round_idx_o    = idx_q;
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Self-checking bench for keccak_round_ctrl against a round-counting reference model.
module tb_keccak_round_ctrl;
    localparam int ROUNDS = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              ack = 1'b0;
    logic              in_ready, round_en, first_round, last_round, busy, out_valid;
    logic [ROUNDS-1:0] round_onehot;
    logic [4:0]        round_idx;

    int passed = 0;
    int total  = 0;

    // Reference model: 0 = idle, 1 = running round rnd, 2 = result held.
    int mode = 0;
    int rnd  = 0;

    keccak_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .out_ack_i      (ack),
        .in_ready_o     (in_ready),
        .round_onehot_o (round_onehot),
        .round_en_o     (round_en),
        .first_round_o  (first_round),
        .last_round_o   (last_round),
        .busy_o         (busy),
`ifdef ROUND_IDX_BIN_EN
        .round_idx_o    (round_idx),
`endif
        .out_valid_o    (out_valid)
    );

`ifndef ROUND_IDX_BIN_EN
    assign round_idx = 5'd0;
`endif

    always #5 clk = ~clk;

    function automatic logic [34:0] observed();
        return {in_ready, busy, round_en, first_round, last_round, out_valid, round_onehot, round_idx};
    endfunction

    function automatic logic [34:0] expected();
        logic [ROUNDS-1:0] oh;
        logic [4:0]        ix;
        logic              run;
        run = (mode == 1);
        oh  = run ? (ROUNDS'(1) << rnd) : '0;
`ifdef ROUND_IDX_BIN_EN
        ix  = run ? 5'(rnd) : 5'd0;
`else
        ix  = 5'd0;
`endif
        return {mode == 0, run, run, run && rnd == 0, run && rnd == ROUNDS-1, mode == 2, oh, ix};
    endfunction

    task automatic cyc(input logic s, input logic a);
        start = s;
        ack   = a;
        @(posedge clk);
        if (reset) begin
            mode = 0; rnd = 0;
        end else begin
            case (mode)
                0: if (s) begin mode = 1; rnd = 0; end
                1: if (rnd == ROUNDS-1) mode = 2; else rnd = rnd + 1;
                default: if (a) mode = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (observed() !== expected()) $display("FAIL reset_hold got=%h exp=%h", observed(), expected());
            else passed++;
        end
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        total++;
        if (observed() !== expected()) $display("FAIL reset_idle got=%h exp=%h", observed(), expected());
        else passed++;
    endtask

    task automatic test_single_perm();
        int en_cnt = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        cyc(1'b1, 1'b0);
        for (int c = 1; c <= ROUNDS + 1; c++) begin
            total++;
            if (observed() !== expected()) $display("FAIL single_c%0d got=%h exp=%h", c, observed(), expected());
            else passed++;
            if (round_en) en_cnt++;
            if (first_round) first_cyc = c;
            if (last_round) last_cyc = c;
            if (c <= ROUNDS) cyc(1'b0, 1'b0);
        end
        total++;
        if (en_cnt !== ROUNDS || first_cyc !== 1 || last_cyc !== ROUNDS)
            $display("FAIL single_timing got=en%0d/f%0d/l%0d exp=en%0d/f1/l%0d", en_cnt, first_cyc, last_cyc, ROUNDS, ROUNDS);
        else passed++;
    endtask

    task automatic test_held_done();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (observed() !== expected() || out_valid !== 1'b1)
                $display("FAIL held_done_%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
        cyc(1'b0, 1'b1);
        total++;
        if (observed() !== expected() || in_ready !== 1'b1)
            $display("FAIL ack_release got=%h exp=%h", observed(), expected());
        else passed++;
    endtask

    task automatic test_ignored();
        int en_cnt = 0;
        cyc(1'b1, 1'b0);
        for (int c = 0; c < ROUNDS + 3; c++) begin
            if (round_en) en_cnt++;
            total++;
            if (observed() !== expected()) $display("FAIL ignored_c%0d got=%h exp=%h", c, observed(), expected());
            else passed++;
            cyc(1'b1, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        total++;
        if (en_cnt !== ROUNDS) $display("FAIL ignored_en_count got=%0d exp=%0d", en_cnt, ROUNDS);
        else passed++;
        cyc(1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (observed() !== expected() || in_ready !== 1'b1)
                $display("FAIL no_back_to_back_%0d got=%h exp=%h", c, observed(), expected());
            else passed++;
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        int en_cnt = 0;
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        total++;
        if (round_onehot !== 24'h000400) $display("FAIL round10_index got=%h exp=000400", round_onehot);
        else passed++;
        reset = 1'b1;
        mode = 0; rnd = 0;
        #1;
        total++;
        if (observed() !== expected()) $display("FAIL async_reset got=%h exp=%h", observed(), expected());
        else passed++;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        for (int c = 0; c < ROUNDS + 2; c++) begin
            if (round_en) en_cnt++;
            total++;
            if (observed() !== expected()) $display("FAIL post_reset_c%0d got=%h exp=%h", c, observed(), expected());
            else passed++;
            cyc(1'b0, 1'b0);
        end
        total++;
        if (en_cnt !== ROUNDS) $display("FAIL post_reset_en_count got=%0d exp=%0d", en_cnt, ROUNDS);
        else passed++;
        cyc(1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
            total++;
            if (observed() !== expected()) $display("FAIL random_c%0d got=%h exp=%h", c, observed(), expected());
            else passed++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_perm();
        test_held_done();
        test_ignored();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
